// File: rtl/timer_counter_n.sv
// timer_counter_n: prescaled WIDTH-bit timer with NCH compare
// channels, four counting modes and a flag/mask interrupt.
module timer_counter_n #(
  parameter int WIDTH = 8,
  parameter int NCH   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       addr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [NCH-1:0]   oc,
  output logic             irq
);

  typedef enum logic [1:0] {
    M_NORM,
    M_CTC,
    M_FPWM,
    M_PC
  } mode_t;

  localparam int NF = NCH + 1;
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  mode_t            mode;
  logic [2:0]       cs;
  logic [2*NCH-1:0] com;
  logic [WIDTH-1:0] tcnt;
  logic [NF-1:0]    imsk;
  logic [NF-1:0]    ifr;
  logic [WIDTH-1:0] ocr_buf [NCH];
  logic [WIDTH-1:0] ocr_eff [NCH];
  logic             up;
  logic             blk;
  logic [9:0]       presc;

  logic             wr_ctrl;
  logic             wr_ocm;
  logic             wr_tcnt;
  logic             wr_imsk;
  logic             wr_ifr;
  logic [NCH-1:0]   wr_ocr;

  logic [9:0]       div_m1;
  logic             run;
  logic             tick;
  logic             at_max;
  logic             at_zero;
  logic             buffered;
  logic             load;
  logic             wrap;
  logic [WIDTH-1:0] nxt;
  logic             nxt_up;
  logic             tov;
  logic [NCH-1:0]   match;
  logic [NCH-1:0]   oc_nxt;
  logic [NF-1:0]    w1c;
  logic [NF-1:0]    flag_set;

  assign wr_ctrl = we && (addr == 4'd0);
  assign wr_ocm  = we && (addr == 4'd1);
  assign wr_tcnt = we && (addr == 4'd2);
  assign wr_imsk = we && (addr == 4'd3);
  assign wr_ifr  = we && (addr == 4'd4);

  // OCR write strobes live at 8+i
  always_comb begin
    wr_ocr = '0;
    for (int i = 0; i < NCH; i++)
      wr_ocr[i] = we && (addr == 4'(8 + i));
  end

  // Count source: divider terminal value, or stopped
  always_comb begin
    div_m1 = '0;
    run    = 1'b1;
    unique case (cs)
      3'd1:    div_m1 = 10'd0;
      3'd2:    div_m1 = 10'd7;
      3'd3:    div_m1 = 10'd63;
      3'd4:    div_m1 = 10'd255;
      3'd5:    div_m1 = 10'd1023;
      default: run = 1'b0;
    endcase
  end

  assign tick     = run && (presc >= div_m1);
  assign at_max   = (tcnt == MAX);
  assign at_zero  = (tcnt == '0);
  assign buffered = (mode == M_FPWM) || (mode == M_PC);
  assign load     = tick && at_max;
  assign wrap     = tick && at_max;

  // Prescaler: free-running, parked at 0 while stopped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      presc <= '0;
    else if (!run || tick)
      presc <= '0;
    else
      presc <= presc + 10'd1;
  end

  // Next count value, direction and overflow event per mode
  always_comb begin
    nxt    = tcnt + ONE;
    nxt_up = up;
    tov    = 1'b0;
    unique case (mode)
      M_CTC: begin
        tov = at_max;
        if (tcnt == ocr_eff[0])
          nxt = '0;
      end
      M_PC: begin
        if (up) begin
          if (at_max) begin
            nxt    = tcnt - ONE;
            nxt_up = 1'b0;
          end
        end else if (at_zero) begin
          nxt_up = 1'b1;
          tov    = 1'b1;
        end else begin
          nxt = tcnt - ONE;
        end
      end
      default: tov = at_max;
    endcase
  end

  // Compare against the pre-tick count, skipped once after a TCNT write
  always_comb begin
    match = '0;
    for (int i = 0; i < NCH; i++)
      match[i] = tick && !blk && (tcnt == ocr_eff[i]);
  end

  // Output action per channel; in fast PWM the wrap beats a match
  always_comb begin
    oc_nxt = oc;
    for (int i = 0; i < NCH; i++) begin
      unique case (mode)
        M_NORM, M_CTC: begin
          unique case (com[2*i +: 2])
            2'b00: oc_nxt[i] = 1'b0;
            2'b01: if (match[i]) oc_nxt[i] = ~oc[i];
            default: if (match[i]) oc_nxt[i] = com[2*i];
          endcase
        end
        M_FPWM: begin
          if (!com[2*i+1])
            oc_nxt[i] = 1'b0;
          else if (wrap)
            oc_nxt[i] = ~com[2*i];
          else if (match[i])
            oc_nxt[i] = com[2*i];
        end
        default: begin
          if (!com[2*i+1])
            oc_nxt[i] = 1'b0;
          else if (match[i])
            oc_nxt[i] = up ? com[2*i] : ~com[2*i];
        end
      endcase
    end
  end

  assign w1c      = wr_ifr ? wdata[NF-1:0] : '0;
  assign flag_set = {match, tick && tov};

  // Control, mask and flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode <= M_NORM;
      cs   <= '0;
      com  <= '0;
      imsk <= '0;
      ifr  <= '0;
    end else begin
      if (wr_ctrl) begin
        mode <= mode_t'(wdata[1:0]);
        cs   <= wdata[4:2];
      end
      if (wr_ocm)
        com <= (2*NCH)'(wdata);
      if (wr_imsk)
        imsk <= wdata[NF-1:0];
      ifr <= (ifr & ~w1c) | flag_set;
    end
  end

  // Counter, direction and post-write compare block
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt <= '0;
      up   <= 1'b1;
      blk  <= 1'b0;
    end else begin
      if (wr_tcnt)
        tcnt <= wdata;
      else if (tick)
        tcnt <= nxt;
      if (wr_tcnt)
        blk <= 1'b1;
      else if (tick)
        blk <= 1'b0;
      if (mode != M_PC)
        up <= 1'b1;
      else if (tick)
        up <= nxt_up;
    end
  end

  // OCR buffers; PWM modes latch them at the top of the count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        ocr_buf[i] <= '0;
        ocr_eff[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_ocr[i])
          ocr_buf[i] <= wdata;
        if (!buffered || load)
          ocr_eff[i] <= wr_ocr[i] ? wdata : ocr_buf[i];
      end
    end
  end

  // Registered compare outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      oc <= '0;
    else
      oc <= oc_nxt;
  end

  assign irq = |(ifr & imsk);

  // Register read mux
  always_comb begin
    rdata = '0;
    unique case (addr)
      4'd0: rdata = WIDTH'({cs, mode});
      4'd1: rdata = WIDTH'(com);
      4'd2: rdata = tcnt;
      4'd3: rdata = WIDTH'(imsk);
      4'd4: rdata = WIDTH'(ifr);
      default: ;
    endcase
    for (int i = 0; i < NCH; i++)
      if (addr == 4'(8 + i))
        rdata = ocr_buf[i];
  end

endmodule

// File: tb/tb_timer_counter_n.sv
// tb_timer_counter_n: directed checks of timer_counter_n with
// a queue of expected values popped at each observation.
module tb_timer_counter_n;

  logic       clk;
  logic       rst;
  logic [3:0] addr;
  logic       we;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [1:0] oc;
  logic       irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  string       tq[$];
  logic [31:0] eq[$];

  timer_counter_n #(.WIDTH(8), .NCH(2)) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .we(we),
    .wdata(wdata),
    .rdata(rdata),
    .oc(oc),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input string t, input logic [31:0] e);
    tq.push_back(t);
    eq.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (tq.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%0h expected=entry", obs);
    end else begin
      t = tq.pop_front();
      e = eq.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic wait_oc(input int ch, input logic lvl,
                         input int lim, input string t);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      #1;
      if (oc[ch] === lvl) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s observed=timeout expected=oc%0d==%0b",
             t, ch, lvl);
    end
  endtask

  task automatic wait_reg(input logic [3:0] a, input logic [7:0] m,
                          input logic [7:0] val, input int lim,
                          input string t);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      addr = a;
      #1;
      if ((rdata & m) === val) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s observed=timeout expected=%0h", t, val);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int cnt, tog, first, last, mx;
    int r1, f1, r2, t1, t2;
    bit tov_seen;
    logic prev;

    rst = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // reset state
    push("rst_ctrl", 0);  rd(0, v); check(v);
    push("rst_tcnt", 0);  rd(2, v); check(v);
    push("rst_oc", 0);    check(oc);
    push("rst_irq", 0);   check(irq);

    // clk/1 counting, then asynchronous reset mid-cycle
    wr(0, 8'h04);
    repeat (20) @(negedge clk);
    push("cnt_clk1", 20);     rd(2, v); check(v);
    push("ifr_pre_rst", 6);   rd(4, v); check(v);
    rst = 1'b0;
    push("arst_ifr", 0);  rd(4, v); check(v);
    push("arst_tcnt", 0); rd(2, v); check(v);
    push("arst_oc", 0);   check(oc);
    push("arst_irq", 0);  check(irq);
    @(negedge clk);
    rst = 1'b1;
    push("post_rst_ctrl", 0); rd(0, v); check(v);
    wr(0, 8'h04);
    repeat (3) @(negedge clk);
    push("resume3", 3); rd(2, v); check(v);

    // normal-mode overflow and IFR write-1-to-clear
    wr(0, 8'h00);
    wr(8, 8'h55);
    wr(9, 8'h66);
    wr(4, 8'hFF);
    wr(2, 8'hFE);
    wr(3, 8'h01);
    wr(0, 8'h04);
    push("ov_fe", 8'hFE); rd(2, v); check(v);
    @(negedge clk);
    push("ov_ff", 8'hFF); rd(2, v); check(v);
    @(negedge clk);
    push("ov_wrap", 0);   rd(2, v); check(v);
    push("ov_ifr", 1);    rd(4, v); check(v);
    push("ov_irq", 1);    check(irq);
    wr(4, 8'h01);
    push("w1c_ifr", 0);   rd(4, v); check(v);
    push("w1c_irq", 0);   check(irq);
    wr(2, 8'hFD);
    @(negedge clk);
    @(negedge clk);
    wr(4, 8'h01);
    push("setclr_ifr", 1); rd(4, v); check(v);
    push("setclr_irq", 1); check(irq);
    push("unmapped5", 0);  rd(5, v); check(v);
    push("unmapped15", 0); rd(15, v); check(v);

    // CTC toggle at clk/8, TOP = 9
    wr(0, 8'h00);
    wr(2, 8'h00);
    wr(8, 8'h09);
    wr(1, 8'h01);
    wr(4, 8'hFF);
    wr(0, 8'h09);
    push("ctc_ctrl", 8'h09); rd(0, v); check(v);
    push("ctc_ocm", 8'h01);  rd(1, v); check(v);
    push("ctc_toggles", 5);
    push("ctc_first", 80);
    push("ctc_last", 400);
    push("ctc_max", 9);
    push("ctc_tov", 0);
    push("ctc_ocf", 1);
    prev = oc[0]; tog = 0; first = 0; last = 0; mx = 0;
    tov_seen = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      addr = 2;
      #1;
      if (int'(rdata) > mx) mx = int'(rdata);
      addr = 4;
      #1;
      tov_seen = tov_seen | rdata[0];
      if (oc[0] !== prev) begin
        tog++;
        if (first == 0) first = k;
        last = k;
        prev = oc[0];
      end
    end
    check(tog);
    check(first);
    check(last);
    check(mx);
    check(tov_seen);
    rd(4, v);
    check(v[1]);

    // fast PWM on channel 1
    wr(0, 8'h00);
    wr(9, 8'h3F);
    wr(1, 8'h08);
    wr(2, 8'h00);
    wr(4, 8'hFF);
    wr(0, 8'h06);
    repeat (300) @(negedge clk);
    push("pwm_duty64", 64);
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      #1;
      if (oc[1]) cnt++;
    end
    check(cnt);
    wait_reg(2, 8'hFF, 8'h10, 600, "pwm_sync");
    wr(9, 8'h80);
    push("pwm_ocr_rd", 8'h80); rd(9, v); check(v);
    wait_oc(1, 1'b0, 300, "pwm_fall_old");
    push("pwm_old_duty", 8'h40); rd(2, v); check(v);
    wait_oc(1, 1'b1, 300, "pwm_rise");
    r1 = cyc;
    wait_oc(1, 1'b0, 300, "pwm_fall_new");
    f1 = cyc;
    push("pwm_duty129", 129); check(f1 - r1);
    wr(9, 8'hFF);
    repeat (300) @(negedge clk);
    push("pwm_full", 0);
    cnt = 0;
    for (int k = 0; k < 512; k++) begin
      @(negedge clk);
      #1;
      if (!oc[1]) cnt++;
    end
    check(cnt);

    // phase-correct on channel 0
    wr(0, 8'h00);
    wr(8, 8'h40);
    wr(1, 8'h02);
    wr(2, 8'h00);
    wr(4, 8'hFF);
    wr(0, 8'h07);
    wait_oc(0, 1'b1, 1200, "pc_rise1");
    r1 = cyc;
    wait_oc(0, 1'b0, 300, "pc_fall");
    f1 = cyc;
    wait_oc(0, 1'b1, 600, "pc_rise2");
    r2 = cyc;
    push("pc_high128", 128); check(f1 - r1);
    push("pc_period", 510);  check(r2 - r1);
    wait_reg(2, 8'hFF, 8'h80, 600, "pc_sync");
    wr(4, 8'hFF);
    wait_reg(4, 8'h01, 8'h01, 600, "pc_tov1");
    t1 = cyc;
    push("pc_tov_at", 1);    rd(2, v); check(v);
    push("pc_tov_oc", 1);    check(oc[0]);
    wr(4, 8'h01);
    wait_reg(4, 8'h01, 8'h01, 600, "pc_tov2");
    t2 = cyc;
    push("pc_tov_per", 510); check(t2 - t1);

    // TCNT write landing on a tick, OCR0 = 0x10
    wr(0, 8'h00);
    wr(8, 8'h10);
    wr(1, 8'h00);
    wr(2, 8'h20);
    wr(4, 8'hFF);
    wr(0, 8'h04);
    wr(2, 8'h10);
    push("coll_tcnt", 8'h10); rd(2, v); check(v);
    @(negedge clk);
    push("coll_next", 8'h11); rd(2, v); check(v);
    push("coll_no_ocf", 0);   rd(4, v); check(v);
    wait_reg(4, 8'h02, 8'h02, 600, "coll_ocf");
    push("coll_ocf_at", 8'h11); rd(2, v); check(v);
    push("coll_ifr", 8'h07);    rd(4, v); check(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
